// File: rtl/miss_arbiter_pkg.sv
// Shared types and constants for the icache/dcache miss arbiter.
package miss_arbiter_pkg;

  localparam int MISS_INFO_W = 149;
  localparam int MISS_DATA_W = 128;

  localparam logic ICACHE_ID = 1'b0;
  localparam logic DCACHE_ID = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESPOND,
    COOLDOWN
  } miss_state_e;

endpackage

// File: rtl/miss_arbiter_if.sv
// Bundle of the core-side miss request/response signals and the memory port.
interface miss_arbiter_if
  import miss_arbiter_pkg::*;
#(
  parameter int INFO_W = MISS_INFO_W,
  parameter int DATA_W = MISS_DATA_W
);

  logic              icache_req_valid_miss;
  logic [INFO_W-1:0] icache_req_info_miss;
  logic              dcache_req_valid_miss;
  logic [INFO_W-1:0] dcache_req_info_miss;

  logic              mem_req_valid;
  logic [INFO_W-1:0] mem_req_info;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_bus_error;

  logic              rsp_valid_miss;
  logic [DATA_W-1:0] rsp_data_miss;
  logic              rsp_bus_error;
  logic              rsp_cache_id;
  logic              busy;

  // Arbiter view.
  modport slave (
    input  icache_req_valid_miss, icache_req_info_miss,
    input  dcache_req_valid_miss, dcache_req_info_miss,
    output mem_req_valid, mem_req_info,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error,
    output rsp_valid_miss, rsp_data_miss, rsp_bus_error, rsp_cache_id, busy
  );

  // Environment view: caches plus memory.
  modport master (
    output icache_req_valid_miss, icache_req_info_miss,
    output dcache_req_valid_miss, dcache_req_info_miss,
    input  mem_req_valid, mem_req_info,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error,
    input  rsp_valid_miss, rsp_data_miss, rsp_bus_error, rsp_cache_id, busy
  );

endinterface

// File: rtl/miss_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester not served last wins.
module rr_arbiter2
  import miss_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = ICACHE_ID;
    if (&req) begin
      gnt_id = ~last_grant;
    end else if (req[DCACHE_ID]) begin
      gnt_id = DCACHE_ID;
    end
  end

endmodule

// File: rtl/miss_arbiter.sv
// Shares one memory port between icache and dcache misses, one outstanding miss
// at a time, with round-robin grant and a response timeout.
module miss_arbiter
  import miss_arbiter_pkg::*;
#(
  parameter int INFO_W         = MISS_INFO_W,
  parameter int DATA_W         = MISS_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic           clock,
  input  logic           reset,
  miss_arbiter_if.slave  bus
);

  miss_state_e       state_q, state_d;
  logic              grant_id_q;
  logic              last_grant_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic [INFO_W-1:0] gnt_info;
  logic              to_hit;
  logic              rsp_take;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;

  rr_arbiter2 u_rr (
    .req        ({bus.dcache_req_valid_miss, bus.icache_req_valid_miss}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign gnt_info = (gnt_id == DCACHE_ID) ? bus.dcache_req_info_miss
                                          : bus.icache_req_info_miss;
  assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_take   = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.mem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        // A response landing on the timeout cycle takes priority over the timeout.
        if (bus.mem_rsp_valid) begin
          rsp_take   = 1'b1;
          rsp_data_d = bus.mem_rsp_data;
          rsp_err_d  = bus.mem_rsp_bus_error;
          state_d    = RESPOND;
        end else if (to_hit) begin
          rsp_take = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND:  state_d = COOLDOWN;
      // The served cache still shows valid here, so requests are ignored.
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_id_q         <= ICACHE_ID;
      last_grant_q       <= ICACHE_ID;
      to_cnt_q           <= '0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_info   <= '0;
      bus.rsp_valid_miss <= 1'b0;
      bus.rsp_data_miss  <= '0;
      bus.rsp_bus_error  <= 1'b0;
      bus.rsp_cache_id   <= ICACHE_ID;
      bus.busy           <= 1'b0;
    end else begin
      bus.busy           <= (state_d != IDLE);
      bus.rsp_valid_miss <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            grant_id_q        <= gnt_id;
            bus.mem_req_info  <= gnt_info;
            bus.mem_req_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            to_cnt_q          <= '0;
          end
        end
        WAIT_RSP: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (rsp_take) begin
            bus.rsp_valid_miss <= 1'b1;
            bus.rsp_data_miss  <= rsp_data_d;
            bus.rsp_bus_error  <= rsp_err_d;
            bus.rsp_cache_id   <= grant_id_q;
          end
        end
        RESPOND: begin
          last_grant_q <= grant_id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_arbiter.sv
// Directed bench for miss_arbiter with a response scoreboard fed by the stimulus.
module tb_miss_arbiter;
  import miss_arbiter_pkg::*;

  typedef struct packed {
    logic [127:0] data;
    logic         err;
    logic         id;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  bit   prev_rsp = 1'b0;

  miss_arbiter_if #(.INFO_W(149), .DATA_W(128)) bus ();

  miss_arbiter #(
    .INFO_W         (149),
    .DATA_W         (128),
    .TIMEOUT_CYCLES (8),
    .TO_W           (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, 256'(bus.mem_req_valid), 256'(0));
    chk({tag, "_mem_req_info"},  256'(bus.mem_req_info),  256'(0));
    chk({tag, "_rsp_valid"},     256'(bus.rsp_valid_miss), 256'(0));
    chk({tag, "_rsp_data"},      256'(bus.rsp_data_miss), 256'(0));
    chk({tag, "_rsp_err"},       256'(bus.rsp_bus_error), 256'(0));
    chk({tag, "_rsp_id"},        256'(bus.rsp_cache_id),  256'(0));
    chk({tag, "_busy"},          256'(bus.busy),          256'(0));
  endtask

  // Acts as memory for one transaction; rsp_dly < 0 means memory never answers.
  task automatic serve(input logic [148:0] info, input int rdy_dly, input int rsp_dly,
                       input logic [127:0] data, input logic err, input logic id,
                       output int waited);
    waited = 0;
    while (!bus.mem_req_valid && waited < 40) begin
      step();
      waited++;
    end
    chk("req_valid", 256'(bus.mem_req_valid), 256'(1));
    if (!bus.mem_req_valid) return;
    chk("req_info", 256'(bus.mem_req_info), 256'(info));
    repeat (rdy_dly) begin
      step();
      chk("hold_valid", 256'(bus.mem_req_valid), 256'(1));
      chk("hold_info",  256'(bus.mem_req_info),  256'(info));
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("req_drop", 256'(bus.mem_req_valid), 256'(0));
    if (rsp_dly >= 0) begin
      repeat (rsp_dly) step();
      exp_q.push_back({data, err, id});
      bus.mem_rsp_valid     = 1'b1;
      bus.mem_rsp_data      = data;
      bus.mem_rsp_bus_error = err;
      step();
      bus.mem_rsp_valid     = 1'b0;
      bus.mem_rsp_data      = '0;
      bus.mem_rsp_bus_error = 1'b0;
    end
  endtask

  // Response monitor.
  always @(negedge clock) begin
    if (!reset) begin
      prev_rsp = 1'b0;
    end else begin
      if (bus.rsp_valid_miss) begin
        chk("rsp_pulse_width", 256'(prev_rsp), 256'(0));
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 256'(bus.rsp_valid_miss), 256'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data",     256'(bus.rsp_data_miss), 256'(e.data));
          chk("rsp_bus_error", 256'(bus.rsp_bus_error), 256'(e.err));
          chk("rsp_cache_id",  256'(bus.rsp_cache_id),  256'(e.id));
        end
      end
      prev_rsp = bus.rsp_valid_miss;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.icache_req_valid_miss = 1'b0;
    bus.icache_req_info_miss  = '0;
    bus.dcache_req_valid_miss = 1'b0;
    bus.dcache_req_info_miss  = '0;
    bus.mem_req_ready         = 1'b0;
    bus.mem_rsp_valid         = 1'b0;
    bus.mem_rsp_data          = '0;
    bus.mem_rsp_bus_error     = 1'b0;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // 1: single icache miss, ready at once, response 3 cycles into WAIT_RSP
    bus.icache_req_valid_miss = 1'b1;
    bus.icache_req_info_miss  = 149'h1ABC;
    serve(149'h1ABC, 0, 3, 128'hDEAD_BEEF, 1'b0, ICACHE_ID, w);
    chk("t1_latency", 256'(w), 256'(1));
    chk("t1_rsp_visible", 256'(bus.rsp_valid_miss), 256'(1));
    bus.icache_req_valid_miss = 1'b0;
    step();
    step();
    chk("t1_idle", 256'(bus.busy), 256'(0));

    // 2: both caches from reset; dcache wins first, then strict alternation
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.icache_req_valid_miss = 1'b1;
    bus.icache_req_info_miss  = 149'h111;
    bus.dcache_req_valid_miss = 1'b1;
    bus.dcache_req_info_miss  = 149'h222;
    for (int i = 0; i < 4; i++) begin
      serve((i % 2 == 0) ? 149'h222 : 149'h111, 0, 1, 128'h2001 + 128'(i), 1'b0,
            (i % 2 == 0) ? DCACHE_ID : ICACHE_ID, w);
    end
    bus.icache_req_valid_miss = 1'b0;
    bus.dcache_req_valid_miss = 1'b0;

    // 3: ready low for 7 cycles; memory error bit forwarded
    bus.dcache_req_valid_miss = 1'b1;
    bus.dcache_req_info_miss  = 149'h333;
    serve(149'h333, 7, 6, 128'h3003, 1'b1, DCACHE_ID, w);
    bus.dcache_req_valid_miss = 1'b0;

    // 4: timeout after 8 cycles in WAIT_RSP
    bus.icache_req_valid_miss = 1'b1;
    bus.icache_req_info_miss  = 149'h444;
    serve(149'h444, 0, -1, 128'h0, 1'b0, ICACHE_ID, w);
    exp_q.push_back({128'h0, 1'b1, ICACHE_ID});
    repeat (7) step();
    chk("t4_no_early_rsp", 256'(bus.rsp_valid_miss), 256'(0));
    step();
    chk("t4_rsp_valid", 256'(bus.rsp_valid_miss), 256'(1));
    chk("t4_rsp_err",   256'(bus.rsp_bus_error),  256'(1));
    chk("t4_rsp_data",  256'(bus.rsp_data_miss),  256'(0));
    bus.icache_req_valid_miss = 1'b0;
    step();
    chk("t4_pulse_end", 256'(bus.rsp_valid_miss), 256'(0));
    step();
    chk("t4_idle", 256'(bus.busy), 256'(0));

    // 5: response on the timeout cycle wins
    bus.dcache_req_valid_miss = 1'b1;
    bus.dcache_req_info_miss  = 149'h555;
    serve(149'h555, 0, 7, 128'hCAFE, 1'b0, DCACHE_ID, w);
    chk("t5_rsp_valid", 256'(bus.rsp_valid_miss), 256'(1));
    chk("t5_rsp_err",   256'(bus.rsp_bus_error),  256'(0));
    chk("t5_rsp_data",  256'(bus.rsp_data_miss),  256'(128'hCAFE));
    bus.dcache_req_valid_miss = 1'b0;
    step();
    step();

    // 6: async reset in WAIT_RSP, then a stale response
    bus.icache_req_valid_miss = 1'b1;
    bus.icache_req_info_miss  = 149'h666;
    serve(149'h666, 0, -1, 128'h0, 1'b0, ICACHE_ID, w);
    step();
    chk("t6_busy_before", 256'(bus.busy), 256'(1));
    #2;
    reset = 1'b0;
    bus.icache_req_valid_miss = 1'b0;
    #1;
    chk_all_zero("t6_async");
    step();
    step();
    reset = 1'b1;
    bus.mem_rsp_valid     = 1'b1;
    bus.mem_rsp_data      = 128'hBAD;
    bus.mem_rsp_bus_error = 1'b1;
    step();
    bus.mem_rsp_valid     = 1'b0;
    bus.mem_rsp_data      = '0;
    bus.mem_rsp_bus_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_rsp",  256'(bus.rsp_valid_miss), 256'(0));
      chk("t6_no_busy", 256'(bus.busy),           256'(0));
    end

    step();
    chk("sb_drain", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/miss_arbiter.md
Name: miss_arbiter

Overview:
- Shares one external memory port between the core's instruction-cache and data-cache miss paths.
- Grants one outstanding miss at a time, using round-robin between the two caches.
- Forwards the granted request to memory and waits for the memory response, or for a timeout.
- Returns the response on the core's shared miss-response bus, tagged with rsp_cache_id (0 = icache, 1 = dcache).
- Sits between the core top and the memory/bus interface.

Parameters:
- INFO_W, 149, width of the miss request info payload (opaque to this block).
- DATA_W, 128, width of the miss response line data.
- TIMEOUT_CYCLES, 1024, number of cycles in WAIT_RSP without a response before a bus error is returned; must be at least 2.
- TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- icache_req_valid_miss  in  1  icache miss pending; held high until its response is seen.
- icache_req_info_miss  in  INFO_W  icache miss payload.
- dcache_req_valid_miss  in  1  dcache miss pending; held high until its response is seen.
- dcache_req_info_miss  in  INFO_W  dcache miss payload.
- mem_req_valid  out  1  request to memory.
- mem_req_info  out  INFO_W  payload of the granted request.
- mem_req_ready  in  1  memory accepts the request in this cycle.
- mem_rsp_valid  in  1  memory response strobe.
- mem_rsp_data  in  DATA_W  response line data.
- mem_rsp_bus_error  in  1  memory reports an error.
- rsp_valid_miss  out  1  one-cycle response pulse to the core.
- rsp_data_miss  out  DATA_W  response data.
- rsp_bus_error  out  1  error flag qualifying rsp_valid_miss.
- rsp_cache_id  out  1  destination of the response: 0 = icache, 1 = dcache.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; every output 0; last_grant = 0 (icache), so dcache wins the first tie.
- States and transitions:
  - IDLE:
    - If any valid is high, grant one requester and go to ISSUE.
    - If both are valid, grant the requester that is not last_grant.
    - Latch grant_id and the granted payload. Load mem_req_info and set mem_req_valid = 1 on the next edge.
    - Latency: a request seen in IDLE at cycle N gives mem_req_valid high at cycle N+1.
  - ISSUE:
    - Hold mem_req_valid and mem_req_info stable until mem_req_ready = 1.
    - On ready: drop mem_req_valid, clear the timeout counter, go to WAIT_RSP.
    - mem_rsp_valid in this state is a protocol violation: ignore it, with no output effect.
    - The requester's valid is not rechecked after the grant; the grant is committed.
  - WAIT_RSP:
    - The timeout counter increments every cycle.
    - On mem_rsp_valid: register rsp_data_miss = mem_rsp_data, rsp_bus_error = mem_rsp_bus_error, rsp_cache_id = grant_id; go to RESPOND.
    - If the counter reaches TIMEOUT_CYCLES-1 with no response: rsp_data_miss = 0, rsp_bus_error = 1, rsp_cache_id = grant_id; go to RESPOND.
    - If mem_rsp_valid arrives in the same cycle as the timeout, the response wins and the error bit comes from memory.
  - RESPOND:
    - rsp_valid_miss = 1 for exactly one cycle.
    - Set last_grant = grant_id. Go to COOLDOWN.
  - COOLDOWN:
    - One cycle. Requester valids are ignored so that the just-served cache, which is still showing valid, is not granted twice. Return to IDLE.
    - rsp_valid_miss = 0. rsp_data_miss, rsp_cache_id and rsp_bus_error hold their values until the next response.
- Minimum turnaround: IDLE → ISSUE → (ready) → WAIT_RSP → RESPOND → COOLDOWN → IDLE, giving one miss per at least 5 cycles.
- Fairness: with both caches continuously requesting, grants strictly alternate.
- Reset asserted mid-operation:
  - The state machine returns to IDLE immediately (asynchronously) and all outputs clear.
  - Any in-flight memory transaction is abandoned; a late mem_rsp_valid seen in IDLE is ignored.
- The payload is never inspected or modified.

Decomposition:
- Shared package:
  - State enum: IDLE, ISSUE, WAIT_RSP, RESPOND, COOLDOWN.
  - Cache-id constants: ICACHE_ID = 0, DCACHE_ID = 1.
  - Widths: INFO_W = 149, DATA_W = 128.
- Sub-module rr_arbiter2: a two-requester round-robin arbiter (combinational grant, last_grant input). It is natural to split out and unit-test on its own; everything else stays in miss_arbiter.

Test Plan:
1. Single icache miss.
   - Stimulus: icache valid with info = 149'h1ABC; mem_req_ready = 1 immediately; mem_rsp_valid 3 cycles later with data = 128'hDEAD_BEEF.
   - Required response: mem_req_info = 149'h1ABC one cycle after valid; one rsp_valid_miss pulse with data DEAD_BEEF, rsp_cache_id = 0, rsp_bus_error = 0.
2. Both caches request continuously from reset.
   - Required response: grant order dcache, icache, dcache, icache; the rsp_cache_id sequence is 1, 0, 1, 0; each cache receives exactly one response per request.
3. Backpressure.
   - Stimulus: mem_req_ready held low for 7 cycles.
   - Required response: mem_req_valid and mem_req_info stay constant for those 7 cycles; the timeout counter does not run; the transaction completes normally after ready.
4. Timeout.
   - Stimulus: TIMEOUT_CYCLES = 8; the memory never responds.
   - Required response: rsp_valid_miss with rsp_bus_error = 1 and data 0 exactly 8 cycles after entering WAIT_RSP; the arbiter then returns to IDLE.
5. Response and timeout in the same cycle.
   - Stimulus: mem_rsp_valid arrives on the timeout cycle with mem_rsp_bus_error = 0.
   - Required response: rsp_bus_error = 0 and the memory data is forwarded.
6. Reset in WAIT_RSP, then a stale response.
   - Stimulus: reset asserted during WAIT_RSP; a stale mem_rsp_valid arrives afterwards.
   - Required response: all outputs are 0 asynchronously, busy = 0, and no rsp_valid_miss is generated.
